// File: rtl/ctrl_sequencer_if.sv
// Sequencer-side bundle: instruction memory, ALU result and register-file controls.
// The master modport is the sequencer. The slave modport is memory/ALU/regfile.
interface ctrl_sequencer_if #(
  parameter int unsigned PC_W = 8
);
  logic            i_start;
  logic [8:0]      i_instr;
  logic [7:0]      i_alu_out;
  logic [PC_W-1:0] o_pc;
  logic [2:0]      o_op;
  logic [2:0]      o_ra_addr;
  logic [2:0]      o_rb_addr;
  logic            o_reg_wr_en_c;
  logic            o_flag;
  logic            o_busy;
  logic            o_done;

  modport master (
    input  i_start, i_instr, i_alu_out,
    output o_pc, o_op, o_ra_addr, o_rb_addr, o_reg_wr_en_c, o_flag, o_busy, o_done
  );

  modport slave (
    output i_start, i_instr, i_alu_out,
    input  o_pc, o_op, o_ra_addr, o_rb_addr, o_reg_wr_en_c, o_flag, o_busy, o_done
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// Three-cycle fetch/decode/execute sequencer for the 8-bit basic processor.
// It drives the PC, the ALU opcode and the register-file controls, and it holds the compare flag.
module ctrl_sequencer #(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  ctrl_sequencer_if.master    bus
);

  localparam int unsigned IR_W = 9;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [2:0] OP_SNE  = 3'b100;
  localparam logic [2:0] OP_SEQ  = 3'b101;
  localparam logic [2:0] OP_CTRL = 3'b111;
  localparam logic [2:0] CT_HALT = 3'b000;
  localparam logic [2:0] CT_BRF  = 3'b001;

  logic [2:0]      r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic [IR_W-1:0] r_ir, w_ir_nxt;
  logic            r_flag, w_flag_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            w_reg_wr_en;
  logic [2:0]      w_op;
  logic [2:0]      w_ctrl;
  logic [PC_W-1:0] w_br_off;
  logic            w_unused_alu;

  assign w_op     = r_ir[8:6];
  assign w_ctrl   = r_ir[5:3];
  assign w_br_off = {{(PC_W-3){r_ir[2]}}, r_ir[2:0]};

  // Only the compare bit of the ALU result matters here.
  assign w_unused_alu = ^bus.i_alu_out[7:1];

  // Next-state and datapath decode.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_flag_nxt  = r_flag;
    w_reg_wr_en = 1'b0;

    case (r_state)
      S_IDLE, S_HALT: begin
        if (bus.i_start) begin
          w_state_nxt = S_FETCH;
          w_pc_nxt    = START_PC;
          w_flag_nxt  = 1'b0;
        end
      end
      S_FETCH: w_state_nxt = S_DECODE;
      S_DECODE: begin
        w_ir_nxt    = bus.i_instr;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        w_state_nxt = S_FETCH;
        w_pc_nxt    = r_pc + PC_W'(1);
        case (w_op)
          OP_SNE, OP_SEQ: w_flag_nxt = bus.i_alu_out[0];
          OP_CTRL: begin
            if (w_ctrl == CT_HALT) begin
              w_state_nxt = S_HALT;
              w_pc_nxt    = r_pc;
            end else if ((w_ctrl == CT_BRF) && r_flag) begin
              w_pc_nxt = r_pc + w_br_off;
            end
          end
          default: w_reg_wr_en = 1'b1;
        endcase
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt == S_FETCH) || (w_state_nxt == S_DECODE) ||
                 (w_state_nxt == S_EXEC);
    w_done_nxt = (w_state_nxt == S_HALT);
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_pc    <= START_PC;
      r_ir    <= '0;
      r_flag  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_flag  <= w_flag_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.o_pc          = r_pc;
  assign bus.o_op          = r_ir[8:6];
  assign bus.o_ra_addr     = r_ir[5:3];
  assign bus.o_rb_addr     = r_ir[2:0];
  assign bus.o_reg_wr_en_c = w_reg_wr_en;
  assign bus.o_flag        = r_flag;
  assign bus.o_busy        = r_busy;
  assign bus.o_done        = r_done;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer. An ISA-level model pushes one expected record per instruction.
// Each record is popped and compared in that instruction's EXEC cycle and in the cycle that follows.
module tb_ctrl_sequencer;

  typedef struct packed {
    logic [7:0] pc;
    logic [2:0] op;
    logic [2:0] ra;
    logic [2:0] rb;
    logic       wr;
    logic [7:0] pc_nxt;
    logic       flag_nxt;
    logic       halt;
  } exp_t;

  logic clk;
  logic rst;
  logic [8:0] mem     [256];
  logic [7:0] alu_tab [256];
  exp_t       exp_q[$];
  logic [7:0] m_pc;
  logic       m_flag;
  int         n_tests;
  int         n_fail;

  ctrl_sequencer_if #(.PC_W(8)) sif ();

  ctrl_sequencer #(.PC_W(8), .START_PC(8'd0)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory and a per-PC ALU result table.
  always @(posedge clk) sif.i_instr <= mem[sif.o_pc];
  assign sif.i_alu_out = alu_tab[sif.o_pc];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] pc, input logic flag,
                                 input logic [8:0] ins, input logic [7:0] alu);
    exp_t e;
    e.pc       = pc;
    e.op       = ins[8:6];
    e.ra       = ins[5:3];
    e.rb       = ins[2:0];
    e.wr       = !(ins[8:6] == 3'b100 || ins[8:6] == 3'b101 || ins[8:6] == 3'b111);
    e.pc_nxt   = pc + 8'd1;
    e.flag_nxt = flag;
    e.halt     = 1'b0;
    if (ins[8:6] == 3'b100 || ins[8:6] == 3'b101) e.flag_nxt = alu[0];
    if (ins[8:6] == 3'b111) begin
      if (ins[5:3] == 3'b000) begin
        e.halt   = 1'b1;
        e.pc_nxt = pc;
      end else if (ins[5:3] == 3'b001 && flag) begin
        e.pc_nxt = pc + {{5{ins[2]}}, ins[2:0]};
      end
    end
    return e;
  endfunction

  // Pulse Start for one edge and leave the bench at the FETCH negedge.
  task automatic start_prog();
    @(negedge clk) sif.i_start = 1'b1;
    @(negedge clk) sif.i_start = 1'b0;
    m_pc   = 8'd0;
    m_flag = 1'b0;
  endtask

  // Execute one instruction. Entry is at the FETCH negedge, exit is at the following negedge.
  task automatic step(input logic poke_start);
    exp_t e;
    exp_q.push_back(model(m_pc, m_flag, mem[m_pc], alu_tab[m_pc]));
    check_eq("fetch_pc", 32'(sif.o_pc), 32'(m_pc));
    check_eq("fetch_busy", 32'(sif.o_busy), 32'd1);
    @(negedge clk);
    if (poke_start) sif.i_start = 1'b1;
    @(negedge clk);
    sif.i_start = 1'b0;
    check_eq("sb_depth", 32'(exp_q.size()), 32'd1);
    e = exp_q.pop_front();
    check_eq("exec_op", 32'(sif.o_op), 32'(e.op));
    check_eq("exec_ra", 32'(sif.o_ra_addr), 32'(e.ra));
    check_eq("exec_rb", 32'(sif.o_rb_addr), 32'(e.rb));
    check_eq("exec_wr", 32'(sif.o_reg_wr_en_c), 32'(e.wr));
    check_eq("exec_pc", 32'(sif.o_pc), 32'(e.pc));
    check_eq("exec_done", 32'(sif.o_done), 32'd0);
    @(negedge clk);
    check_eq("next_pc", 32'(sif.o_pc), 32'(e.pc_nxt));
    check_eq("next_flag", 32'(sif.o_flag), 32'(e.flag_nxt));
    check_eq("next_done", 32'(sif.o_done), 32'(e.halt));
    check_eq("next_busy", 32'(sif.o_busy), 32'(!e.halt));
    check_eq("next_wr", 32'(sif.o_reg_wr_en_c), 32'd0);
    m_pc   = e.pc_nxt;
    m_flag = e.flag_nxt;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 9'b111_010_000;
      alu_tab[i] = 8'h00;
    end
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    sif.i_start = 1'b0;
    m_pc        = 8'd0;
    m_flag      = 1'b0;
    clear_mem();
    mem[0] = 9'b000_001_010;  // ADD r1,r2
    mem[1] = 9'b011_010_011;  // XOR
    mem[2] = 9'b010_011_001;  // LSR
    mem[3] = 9'b110_100_101;  // MSK
    mem[4] = 9'b101_001_010;  // SEQ
    mem[5] = 9'b111_001_110;  // BRF -2
    mem[7] = 9'b111_001_011;  // BRF +3
    mem[8] = 9'b100_000_000;  // SNE
    mem[9] = 9'b111_000_000;  // HALT
    alu_tab[4] = 8'h01;
    alu_tab[8] = 8'h01;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_pc", 32'(sif.o_pc), 32'd0);
    check_eq("rst_op", 32'(sif.o_op), 32'd0);
    check_eq("rst_ra", 32'(sif.o_ra_addr), 32'd0);
    check_eq("rst_rb", 32'(sif.o_rb_addr), 32'd0);
    check_eq("rst_wr", 32'(sif.o_reg_wr_en_c), 32'd0);
    check_eq("rst_flag", 32'(sif.o_flag), 32'd0);
    check_eq("rst_busy", 32'(sif.o_busy), 32'd0);
    check_eq("rst_done", 32'(sif.o_done), 32'd0);

    // ALU ops, then SEQ sets Flag and the taken BRF goes back to 3. Start is poked once while busy.
    start_prog();
    step(1'b0);
    step(1'b1);
    repeat (4) step(1'b0);
    // Second pass: SEQ clears Flag, both BRFs fall through, then SNE runs, then HALT.
    alu_tab[4] = 8'h00;
    repeat (7) step(1'b0);

    for (int i = 0; i < 10; i++) begin
      check_eq("halt_done", 32'(sif.o_done), 32'd1);
      check_eq("halt_busy", 32'(sif.o_busy), 32'd0);
      check_eq("halt_pc", 32'(sif.o_pc), 32'd9);
      @(negedge clk);
    end

    // Wrap program: a BRF of -4 from 1 lands on 253, then the PC runs through 255 to 0.
    clear_mem();
    mem[0]   = 9'b100_001_001;
    mem[1]   = 9'b111_001_100;
    mem[254] = 9'b111_011_000;
    alu_tab[0] = 8'h01;
    start_prog();
    check_eq("restart_pc", 32'(sif.o_pc), 32'd0);
    check_eq("restart_flag", 32'(sif.o_flag), 32'd0);
    check_eq("restart_busy", 32'(sif.o_busy), 32'd1);
    check_eq("restart_done", 32'(sif.o_done), 32'd0);
    repeat (5) step(1'b0);

    // Async reset during the EXEC of an XOR.
    mem[0] = 9'b011_101_110;
    check_eq("xor_fetch_pc", 32'(sif.o_pc), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check_eq("xor_exec_wr", 32'(sif.o_reg_wr_en_c), 32'd1);
    check_eq("xor_exec_op", 32'(sif.o_op), 32'd3);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_wr", 32'(sif.o_reg_wr_en_c), 32'd0);
    check_eq("arst_pc", 32'(sif.o_pc), 32'd0);
    check_eq("arst_op", 32'(sif.o_op), 32'd0);
    check_eq("arst_busy", 32'(sif.o_busy), 32'd0);
    check_eq("arst_flag", 32'(sif.o_flag), 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("idle_busy", 32'(sif.o_busy), 32'd0);
    check_eq("idle_pc", 32'(sif.o_pc), 32'd0);
    check_eq("idle_done", 32'(sif.o_done), 32'd0);
    check_eq("idle_wr", 32'(sif.o_reg_wr_en_c), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Multi-cycle fetch/decode/execute sequencer for the 8-bit basic processor; sits directly upstream of the ALU. It walks the program counter, latches 9-bit instructions from a synchronous instruction memory, and drives the ALU opcode and register-file read/write controls. It holds the compare flag produced by SNE/SEQ and resolves conditional branches and halt.

## Interface
- PC_W, 8: program counter width; the PC wraps modulo 2^PC_W.
- START_PC, 0: PC value loaded on reset and on every Start.
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; forces every register to its reset value immediately.
- Start  in  1  in IDLE or HALT, begins execution at START_PC.
- Instr  in  9  instruction-memory read data; valid one cycle after PC is presented.
- AluOut  in  8  ALU result; bit 0 is the compare result for SNE/SEQ.
- PC  out  PC_W  instruction-memory address.
- OP  out  3  ALU opcode, equal to IR[8:6].
- RaAddr  out  3  read port A and write address, equal to IR[5:3].
- RbAddr  out  3  read port B address, equal to IR[2:0].
- RegWrEn  out  1  register-file write strobe; writes AluOut to RaAddr.
- Flag  out  1  compare flag.
- Busy  out  1  high in FETCH, DECODE and EXEC.
- Done  out  1  high in HALT.

## Operation
- Instruction fields: IR[8:6] op, IR[5:3] ra, IR[2:0] rb/imm.
- ALU ops (000 ADD, 001 LSL, 010 LSR, 011 XOR, 110 MSK): R[ra] <= R[ra] op R[rb]. RegWrEn=1 in EXEC only.
- Compare ops (100 SNE, 101 SEQ): Flag <= AluOut[0] at the end of EXEC. No register write.
- Op 111 is the control group, selected by IR[5:3]:
  - 000 HALT.
  - 001 BRF: if Flag=1, PC <= PC + sext(IR[2:0]), range -4..+3; otherwise PC <= PC+1. Flag is unchanged.
  - 010 NOP.
  - All other IR[5:3] values are treated as NOP.
- States:
  - IDLE: Start=1 -> FETCH, with PC <= START_PC and Flag <= 0.
  - FETCH: PC is presented to memory -> DECODE.
  - DECODE: IR <= Instr -> EXEC.
  - EXEC: perform the op and update PC.
    - HALT -> HALT with PC held.
    - All other ops -> FETCH with PC updated.
  - HALT: Start=1 -> FETCH, with PC <= START_PC and Flag <= 0. Otherwise stay in HALT.
- Start is ignored in FETCH, DECODE and EXEC.
- PC arithmetic is PC_W bits and wraps: 255+1 -> 0; 1 + (-4) -> 253 with PC_W=8.
- The ALU shift-in is not driven here; the top level ties SC_in to 0.

## Timing
- Reset values: PC=START_PC, IR=0 (so OP=000, RaAddr=0, RbAddr=0), RegWrEn=0, Flag=0, Busy=0, Done=0, state IDLE.
- Every instruction takes exactly 3 cycles (FETCH, DECODE, EXEC).
- The first FETCH occurs the cycle after Start is sampled.
- OP, RaAddr and RbAddr are registered from IR and stable throughout EXEC.
  - The ALU and register-file read path are combinational within EXEC.
- RegWrEn is a combinational decode of state==EXEC and the op type, so it is high for exactly one cycle.
  - The register-file write, Flag update and PC update all occur on the edge that ends EXEC.
- Done rises on the edge that ends a HALT EXEC and stays high until Start or Reset.
- Busy and Done are never high together.
- Reset asserted mid-instruction clears all state and outputs asynchronously.
  - RegWrEn falls within the same cycle and no partial write is committed.
  - The sequencer restarts only on a fresh Start.

## Test plan
- ADD: reset; Start at t0; Instr=9'b000_001_010 at PC 0 -> DECODE at t0+2, EXEC at t0+3. In EXEC, OP=000, RaAddr=1, RbAddr=2, RegWrEn=1 for one cycle. PC=1 at t0+4.
- SEQ then taken BRF:
  - SEQ at PC 4 with AluOut=8'h01 -> Flag=1 and RegWrEn stays 0.
  - BRF 9'b111_001_110 at PC 5 -> PC=3 after its EXEC.
- Untaken BRF: Flag=0, BRF +3 at PC 7 -> PC=8 and Flag remains 0.
- Wrap:
  - NOP at PC 255 -> PC=0.
  - BRF -4 (Flag=1) at PC 1 -> PC=253.
- HALT at PC 9:
  - Done=1, Busy=0, PC holds 9 for 10 cycles.
  - Start pulse -> PC=START_PC, Flag=0, Busy=1 next cycle.
- Reset in the EXEC of an XOR (RegWrEn=1) -> RegWrEn=0, PC=0, OP=000, Busy=0 without waiting for a clock edge. Stays IDLE with no Start.
